// File: rtl/mem_bipo_pp_if.sv
// Bus bundle for mem_bipo_pp: producer write port, consumer read port and
// the page handshake.
//   master : the producer/consumer side (drives requests, sees status/data)
//   slave  : the buffer (mem_bipo_pp)
// Widths: C = LOG2_CU-2 (4x4 coordinate), S = 1<<LOG2_CU (CU side in pixels).
interface mem_bipo_pp_if #(
    parameter int PIXEL_WIDTH = 8,
    parameter int LOG2_CU     = 5
);
    localparam int C = LOG2_CU - 2;
    localparam int S = 1 << LOG2_CU;

    logic                      wen_i;
    logic [C-1:0]              w4x4_x_i;
    logic [C-1:0]              w4x4_y_i;
    logic [16*PIXEL_WIDTH-1:0] wdata_i;
    logic                      wdone_i;
    logic                      wready_o;
    logic                      ren_i;
    logic [2:0]                rsize_i;
    logic [C-1:0]              r4x4_x_i;
    logic [C-1:0]              r4x4_y_i;
    logic [LOG2_CU-1:0]        ridx_i;
    logic                      rdone_i;
    logic                      rvalid_o;
    logic [S*PIXEL_WIDTH-1:0]  rdata_o;
    logic                      rempty_o;
    logic                      werr_o;

    modport master (
        output wen_i, w4x4_x_i, w4x4_y_i, wdata_i, wdone_i,
        output ren_i, rsize_i, r4x4_x_i, r4x4_y_i, ridx_i, rdone_i,
        input  wready_o, rvalid_o, rdata_o, rempty_o, werr_o
    );

    modport slave (
        input  wen_i, w4x4_x_i, w4x4_y_i, wdata_i, wdone_i,
        input  ren_i, rsize_i, r4x4_x_i, r4x4_y_i, ridx_i, rdone_i,
        output wready_o, rvalid_o, rdata_o, rempty_o, werr_o
    );
endinterface

// File: rtl/mem_bipo_pp.sv
// Double-buffered (ping-pong) pixel buffer: 4x4 blocks in, CU-width words out.
// The producer fills page wptr while the consumer drains page rptr; a page is
// handed over with wdone_i (empty -> full) and returned with rdone_i
// (full -> empty). A read word holds 1..8 rows of an NxN sub-block, first row
// in the MSBs, left pixel MSB within a row; reads have one cycle of latency.
// Ports:
//   clk    : clock
//   rst_n  : asynchronous active-low reset
//   bus    : mem_bipo_pp_if.slave (write, read and page handshake signals)
module mem_bipo_pp #(
    parameter int PIXEL_WIDTH = 8,
    parameter int LOG2_CU     = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    mem_bipo_pp_if.slave bus
);
    localparam int S  = 1 << LOG2_CU;
    localparam int PW = PIXEL_WIDTH;

    // Pixel storage is flop-based so any set of rows can be read in one cycle
    // alongside a 4x4 write to the other page. Contents are not reset.
    logic [PW-1:0]   r_mem [2][S][S];

    logic [1:0]      r_full;
    logic            r_wptr;
    logic            r_rptr;
    logic            r_rvalid;
    logic            r_werr;
    logic [S*PW-1:0] r_rdata;

    logic            w_wready;
    logic            w_rempty;
    logic            w_wr;
    logic            w_rd;
    logic            w_commit;
    logic            w_release;
    logic [S*PW-1:0] w_rword;
    int              w_lg_n;
    int              w_lg_r;
    int              w_sel;
    int              w_row;
    int              w_col;

    assign w_wready  = ~r_full[r_wptr];
    assign w_rempty  = ~r_full[r_rptr];
    assign w_wr      = bus.wen_i & w_wready;
    assign w_rd      = bus.ren_i & ~w_rempty;
    assign w_commit  = bus.wdone_i & w_wready;
    assign w_release = bus.rdone_i & ~w_rempty;

    assign bus.wready_o = w_wready;
    assign bus.rempty_o = w_rempty;
    assign bus.rvalid_o = r_rvalid;
    assign bus.rdata_o  = r_rdata;
    assign bus.werr_o   = r_werr;

    // Pixel (i,j) of the incoming block sits at index 4*i+j counted from the MSB.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            for (int i = 0; i < 4; i++) begin
                for (int j = 0; j < 4; j++) begin
                    r_mem[r_wptr][{bus.w4x4_y_i, i[1:0]}][{bus.w4x4_x_i, j[1:0]}]
                        <= bus.wdata_i[(15 - (i*4 + j))*PW +: PW];
                end
            end
        end
    end

    // Output pixel p (p=0 at the MSBs) maps to block row p/N and column p%N.
    // For N>=8 the word carries R = S/N rows, so the row group starts at
    // (ridx mod N/R)*R. Requests with N > S leave the word at zero.
    always_comb begin
        w_rword = '0;
        w_lg_n  = int'(bus.rsize_i) + 2;
        w_lg_r  = LOG2_CU - w_lg_n;
        w_sel   = 0;
        w_row   = 0;
        w_col   = 0;
        if (bus.rsize_i == 3'd0) begin
            for (int p = 0; p < 16; p++) begin
                w_row = 4*int'(bus.r4x4_y_i) + (p >> 2);
                w_col = 4*int'(bus.r4x4_x_i) + (p & 3);
                if (w_row < S && w_col < S) begin
                    w_rword[(S-1-p)*PW +: PW] =
                        r_mem[r_rptr][w_row[LOG2_CU-1:0]][w_col[LOG2_CU-1:0]];
                end
            end
        end else if (w_lg_n <= LOG2_CU) begin
            w_sel = int'(bus.ridx_i) & ((1 << (w_lg_n - w_lg_r)) - 1);
            for (int p = 0; p < S; p++) begin
                w_row = 4*int'(bus.r4x4_y_i) + (w_sel << w_lg_r) + (p >> w_lg_n);
                w_col = 4*int'(bus.r4x4_x_i) + (p & ((1 << w_lg_n) - 1));
                if (w_row < S && w_col < S) begin
                    w_rword[(S-1-p)*PW +: PW] =
                        r_mem[r_rptr][w_row[LOG2_CU-1:0]][w_col[LOG2_CU-1:0]];
                end
            end
        end
    end

    // Commit and release always address different pages (write page is
    // empty, read page is full), so both may update r_full in one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full   <= 2'b00;
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_rvalid <= 1'b0;
            r_werr   <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_werr   <= bus.wen_i & ~w_wready;
            r_rvalid <= w_rd;
            if (w_rd) begin
                r_rdata <= w_rword;
            end
            if (w_commit) begin
                r_full[r_wptr] <= 1'b1;
                r_wptr         <= ~r_wptr;
            end
            if (w_release) begin
                r_full[r_rptr] <= 1'b0;
                r_rptr         <= ~r_rptr;
            end
        end
    end
endmodule

// File: tb/tb_mem_bipo_pp.sv
module tb_mem_bipo_pp;
    localparam int PW      = 8;
    localparam int LOG2_CU = 5;
    localparam int S       = 32;
    localparam int C       = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_bipo_pp_if #(.PIXEL_WIDTH(PW), .LOG2_CU(LOG2_CU)) bus ();

    mem_bipo_pp #(.PIXEL_WIDTH(PW), .LOG2_CU(LOG2_CU)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // reference model
    logic [PW-1:0]   mdl [2][S][S];
    logic [1:0]      m_full;
    logic            m_wptr, m_rptr, m_werr, m_pend;
    logic [S*PW-1:0] m_last;
    logic [S*PW-1:0] sb_q [$];

    function automatic logic [PW-1:0] pix(int tag, int r, int c);
        return PW'(r*7 + c*13 + tag*59);
    endfunction

    function automatic logic [S*PW-1:0] exp_word(int pg, int rs, int x, int y, int ridx);
        logic [S*PW-1:0] w;
        int n, r, sel;
        w = '0;
        n = 4 << rs;
        if (rs == 0) begin
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++)
                    w[(S-1-(4*i+j))*PW +: PW] = mdl[pg][4*y+i][4*x+j];
        end else begin
            r   = S / n;
            sel = ridx % (n / r);
            for (int k = 0; k < r; k++)
                for (int j = 0; j < n; j++)
                    w[(S-1-(k*n+j))*PW +: PW] = mdl[pg][4*y+sel*r+k][4*x+j];
        end
        return w;
    endfunction

    task automatic chk(string tag, logic [S*PW-1:0] obs, logic [S*PW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_full = 2'b00;
        m_wptr = 1'b0;
        m_rptr = 1'b0;
        m_werr = 1'b0;
        m_pend = 1'b0;
        m_last = '0;
        sb_q.delete();
    endtask

    task automatic clear_inputs();
        bus.wen_i   = 1'b0;
        bus.wdone_i = 1'b0;
        bus.ren_i   = 1'b0;
        bus.rdone_i = 1'b0;
    endtask

    // One clock: update the model from the driven inputs, push expected read
    // data, then check every output one delta after the edge.
    task automatic cyc();
        logic wr_ok, rd_ok, cm, rl;
        logic [S*PW-1:0] e;
        wr_ok = !m_full[m_wptr];
        rd_ok = m_full[m_rptr];
        m_pend = 1'b0;
        if (bus.ren_i && rd_ok) begin
            sb_q.push_back(exp_word(int'(m_rptr), int'(bus.rsize_i), int'(bus.r4x4_x_i),
                                    int'(bus.r4x4_y_i), int'(bus.ridx_i)));
            m_pend = 1'b1;
        end
        if (bus.wen_i && wr_ok) begin
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++)
                    mdl[m_wptr][4*int'(bus.w4x4_y_i)+i][4*int'(bus.w4x4_x_i)+j] =
                        bus.wdata_i[(15-(4*i+j))*PW +: PW];
        end
        m_werr = bus.wen_i && !wr_ok;
        cm = bus.wdone_i && wr_ok;
        rl = bus.rdone_i && rd_ok;
        if (cm) begin m_full[m_wptr] = 1'b1; m_wptr = !m_wptr; end
        if (rl) begin m_full[m_rptr] = 1'b0; m_rptr = !m_rptr; end

        @(posedge clk);
        #1;
        chk("rvalid", bus.rvalid_o, m_pend);
        if (bus.rvalid_o) begin
            e = (sb_q.size() > 0) ? sb_q.pop_front() : 'x;
            chk("rdata", bus.rdata_o, e);
            m_last = e;
        end else begin
            chk("rdata_hold", bus.rdata_o, m_last);
        end
        chk("werr", bus.werr_o, m_werr);
        chk("wready", bus.wready_o, !m_full[m_wptr]);
        chk("rempty", bus.rempty_o, !m_full[m_rptr]);
        clear_inputs();
    endtask

    task automatic wr(int x, int y, int tag, bit done = 1'b0);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                bus.wdata_i[(15-(4*i+j))*PW +: PW] = pix(tag, 4*y+i, 4*x+j);
        bus.w4x4_x_i = C'(x);
        bus.w4x4_y_i = C'(y);
        bus.wen_i    = 1'b1;
        bus.wdone_i  = done;
        cyc();
    endtask

    task automatic set_rd(int rs, int x, int y, int ridx, bit done);
        bus.rsize_i  = 3'(rs);
        bus.r4x4_x_i = C'(x);
        bus.r4x4_y_i = C'(y);
        bus.ridx_i   = LOG2_CU'(ridx);
        bus.ren_i    = 1'b1;
        bus.rdone_i  = done;
    endtask

    task automatic rd(int rs, int x, int y, int ridx, bit done = 1'b0);
        set_rd(rs, x, y, ridx, done);
        cyc();
    endtask

    task automatic fill(int tag);
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++)
                wr(x, y, tag, (x == 7 && y == 7));
    endtask

    initial begin
        logic [S*PW-1:0] e;
        clear_inputs();
        bus.wdata_i  = '0;
        bus.w4x4_x_i = '0;
        bus.w4x4_y_i = '0;
        bus.rsize_i  = '0;
        bus.r4x4_x_i = '0;
        bus.r4x4_y_i = '0;
        bus.ridx_i   = '0;
        model_reset();

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wready", bus.wready_o, 1);
        chk("rst_rempty", bus.rempty_o, 1);
        chk("rst_rvalid", bus.rvalid_o, 0);
        chk("rst_rdata", bus.rdata_o, 0);
        chk("rst_werr", bus.werr_o, 0);
        rst_n = 1'b1;
        cyc();

        // page0: full CU, last block written together with the commit
        fill(0);

        // 32x32 row reads, back to back
        for (int r = 0; r < 32; r++) rd(3, 0, 0, r);
        // sub-block reads
        rd(1, 2, 4, 1);
        rd(0, 3, 1, 17);
        rd(1, 6, 2, 3);
        rd(2, 4, 0, 13);
        rd(2, 0, 4, 2);
        cyc();

        // page1 too: both full, then dropped write with ignored wdone
        fill(1);
        wr(0, 0, 9, 1'b1);
        cyc();
        rd(0, 0, 0, 0);
        rd(3, 0, 0, 2);

        // release page0 while reading it, refill part of it
        rd(3, 0, 0, 5, 1'b1);
        wr(0, 0, 2);
        wr(1, 0, 2);
        wr(0, 1, 2);
        wr(1, 1, 2);
        // commit page0, release page1 and read page1 in one cycle
        bus.wdone_i = 1'b1;
        rd(3, 0, 0, 4, 1'b1);
        rd(1, 0, 0, 0);
        rd(1, 0, 0, 1);
        rd(0, 1, 1, 0);

        // drain page0, then read/release on empty pages
        rd(2, 0, 0, 1, 1'b1);
        rd(3, 0, 0, 0);
        rd(3, 0, 0, 0, 1'b1);
        cyc();

        // reset in the middle of a read
        wr(2, 2, 3, 1'b1);
        set_rd(0, 2, 2, 0, 1'b0);
        e = exp_word(int'(m_rptr), 0, 2, 2, 0);
        @(posedge clk);
        #1;
        clear_inputs();
        chk("midrd_rvalid", bus.rvalid_o, 1);
        chk("midrd_rdata", bus.rdata_o, e);
        rst_n = 1'b0;
        #1;
        chk("arst_rvalid", bus.rvalid_o, 0);
        chk("arst_rdata", bus.rdata_o, 0);
        chk("arst_wready", bus.wready_o, 1);
        chk("arst_rempty", bus.rempty_o, 1);
        chk("arst_werr", bus.werr_o, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc();
        rd(0, 0, 0, 0);
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
